// File: rtl/payment_collector_if.sv
// Purpose : bundles the fee/coin/cancel inputs and gate/change/status outputs of the payment collector.
// Latency : n/a (signal bundle only).
// Backpressure: none; every strobe is a one-cycle pulse that is never stalled.
// Ports   : master = stimulus side (drives cost/coin/cancel), slave = payment_collector.
interface payment_collector_if;
    logic [7:0] cost;
    logic       cost_valid;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       gate_open;
    logic       change_pulse;
    logic       coin_reject;
    logic [7:0] paid_total;
    logic       busy;
    logic [2:0] state;

    modport master (
        output cost, cost_valid, coin_valid, coin_value, cancel,
        input  gate_open, change_pulse, coin_reject, paid_total, busy, state
    );

    modport slave (
        input  cost, cost_valid, coin_valid, coin_value, cancel,
        output gate_open, change_pulse, coin_reject, paid_total, busy, state
    );
endinterface

// File: rtl/payment_collector.sv
// Purpose : parking-style fee collector: takes coins toward a fee, dispenses change/refund pulses, opens the gate.
// Latency : every output is registered; inputs sampled on one edge are visible one cycle later.
// Backpressure: none; coins arriving outside COLLECT, or that would overflow paid_total, get a coin_reject pulse.
// Ports   : clk, reset (async active-low), pc (slave modport of payment_collector_if).
module payment_collector #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GATE_HOLD      = 16
) (
    input  logic clk,
    input  logic reset,
    payment_collector_if.slave pc
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // One counter serves change, refund and gate hold; wide enough for both uses.
    localparam int CW = (GATE_HOLD > 255) ? $clog2(GATE_HOLD + 1) : 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHANGE  = 3'd2,
        S_OPEN    = 3'd3,
        S_REFUND  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      due_q, due_d;
    logic [7:0]      paid_q, paid_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gate_q, pulse_q, reject_q, busy_q;
    logic            reject_d;

    logic [3:0]      coin_units;
    logic [8:0]      sum9;
    logic            coin_ok;
    logic [7:0]      total;
    logic            timeout;

    always_comb begin
        case (pc.coin_value)
            2'b00:   coin_units = 4'd1;
            2'b01:   coin_units = 4'd2;
            2'b10:   coin_units = 4'd5;
            default: coin_units = 4'd10;
        endcase
    end

    // Ninth bit of the sum flags a coin that would overflow paid_total.
    assign sum9    = {1'b0, paid_q} + {5'b0, coin_units};
    assign coin_ok = pc.coin_valid && (state_q == S_COLLECT) && !sum9[8];
    // Total including this cycle's coin, so a same-cycle cancel refunds it too.
    assign total   = coin_ok ? sum9[7:0] : paid_q;
    // Fires on the idle cycle that would bring the timer up to TIMEOUT_CYCLES.
    assign timeout = !coin_ok && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        due_d    = due_q;
        paid_d   = paid_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        reject_d = pc.coin_valid && !coin_ok;
        case (state_q)
            S_IDLE: begin
                if (pc.cost_valid) begin
                    due_d   = pc.cost;
                    paid_d  = 8'd0;
                    timer_d = '0;
                    if (pc.cost == 8'd0) begin
                        state_d = S_OPEN;
                        cnt_d   = CW'(GATE_HOLD);
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                paid_d  = total;
                timer_d = coin_ok ? '0 : timer_q + 1'b1;
                // Completion has priority over cancel/timeout.
                if (coin_ok && (total >= due_q)) begin
                    if (total > due_q) begin
                        state_d = S_CHANGE;
                        cnt_d   = CW'(total - due_q);
                    end else begin
                        state_d = S_OPEN;
                        cnt_d   = CW'(GATE_HOLD);
                    end
                end else if (pc.cancel || timeout) begin
                    if (total != 8'd0) begin
                        state_d = S_REFUND;
                        cnt_d   = CW'(total);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_OPEN;
                    cnt_d   = CW'(GATE_HOLD);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OPEN, S_REFUND: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            due_q    <= 8'd0;
            paid_q   <= 8'd0;
            timer_q  <= '0;
            cnt_q    <= '0;
            gate_q   <= 1'b0;
            pulse_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            due_q    <= due_d;
            paid_q   <= paid_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            // Output flops track the next state so they line up with state_q.
            gate_q   <= (state_d == S_OPEN);
            pulse_q  <= (state_d == S_CHANGE) || (state_d == S_REFUND);
            reject_q <= reject_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign pc.gate_open    = gate_q;
    assign pc.change_pulse = pulse_q;
    assign pc.coin_reject  = reject_q;
    assign pc.paid_total   = paid_q;
    assign pc.busy         = busy_q;
    assign pc.state        = state_q;

endmodule

// File: tb/tb_payment_collector.sv
// Purpose : self-checking bench for payment_collector: vector table, directed corner sequences, random run vs model.
// Latency : outputs compared 1 time unit after each rising edge; inputs applied at the same point.
// Backpressure: n/a.
module tb_payment_collector;
    localparam int TIMEOUT = 255;
    localparam int GATE    = 16;
    localparam int ST_IDLE = 0, ST_COLLECT = 1, ST_CHANGE = 2, ST_OPEN = 3, ST_REFUND = 4;

    logic clk;
    logic reset;
    payment_collector_if pc_if ();

    payment_collector #(.TIMEOUT_CYCLES(TIMEOUT), .GATE_HOLD(GATE)) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int gate_cnt = 0;

    // Reference model: a flag for "collecting", and a queue of scheduled dispense/gate
    // cycles built whenever a transaction ends.
    bit m_collect;
    int m_q[$];
    int m_due, m_paid, m_idle;
    bit m_rej;

    function automatic int coin_val(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 10;
        endcase
    endfunction

    function automatic int exp_state();
        if (m_q.size() != 0) return m_q[0];
        return m_collect ? ST_COLLECT : ST_IDLE;
    endfunction

    function automatic void model_reset();
        m_collect = 0;
        m_q.delete();
        m_due = 0; m_paid = 0; m_idle = 0; m_rej = 0;
    endfunction

    function automatic void schedule(input int phase, input int n);
        for (int i = 0; i < n; i++) m_q.push_back(phase);
    endfunction

    function automatic void model_step(input bit cv, input int cost, input bit kv, input int code, input bit cn);
        m_rej = 0;
        if (m_q.size() != 0) begin
            m_rej = kv;
            void'(m_q.pop_front());
        end else if (!m_collect) begin
            m_rej = kv;
            if (cv) begin
                m_due = cost; m_paid = 0; m_idle = 0;
                if (cost == 0) schedule(ST_OPEN, GATE);
                else m_collect = 1;
            end
        end else begin
            bit acc = 0;
            int tot = m_paid;
            if (kv) begin
                if (m_paid + coin_val(code) <= 255) begin acc = 1; tot = m_paid + coin_val(code); end
                else m_rej = 1;
            end
            m_idle = acc ? 0 : m_idle + 1;
            m_paid = tot;
            if (acc && tot >= m_due) begin
                m_collect = 0;
                schedule(ST_CHANGE, tot - m_due);
                schedule(ST_OPEN, GATE);
            end else if (cn || m_idle >= TIMEOUT) begin
                m_collect = 0;
                schedule(ST_REFUND, tot);
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic cmp_model();
        int es = exp_state();
        bit eg = (es == ST_OPEN);
        bit ep = (es == ST_CHANGE) || (es == ST_REFUND);
        bit eb = (es != ST_IDLE);
        checks++;
        if (pc_if.state !== 3'(es) || pc_if.paid_total !== 8'(m_paid) || pc_if.gate_open !== eg ||
            pc_if.change_pulse !== ep || pc_if.busy !== eb || pc_if.coin_reject !== m_rej) begin
            errors++;
            $display("FAIL model t=%0t: got st=%0d paid=%0d gate=%b pulse=%b busy=%b rej=%b expected st=%0d paid=%0d gate=%b pulse=%b busy=%b rej=%b",
                     $time, pc_if.state, pc_if.paid_total, pc_if.gate_open, pc_if.change_pulse, pc_if.busy,
                     pc_if.coin_reject, es, m_paid, eg, ep, eb, m_rej);
        end
    endtask

    task automatic cyc(input bit cv, input int cost, input bit kv, input int code, input bit cn);
        pc_if.cost_valid = cv;
        pc_if.cost       = 8'(cost);
        pc_if.coin_valid = kv;
        pc_if.coin_value = 2'(code);
        pc_if.cancel     = cn;
        model_step(cv, cost, kv, code, cn);
        @(posedge clk);
        #1;
        pc_if.cost_valid = 1'b0;
        pc_if.coin_valid = 1'b0;
        pc_if.cancel     = 1'b0;
        if (pc_if.change_pulse) pulse_cnt++;
        if (pc_if.gate_open) gate_cnt++;
        cmp_model();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (pc_if.state != 3'd0 && n < 600) begin idle(); n++; end
        chk({nm, "_drain_state"}, int'(pc_if.state), ST_IDLE);
    endtask

    task automatic chk_reset(input string nm);
        checks++;
        if (pc_if.state !== 3'd0 || pc_if.gate_open !== 1'b0 || pc_if.change_pulse !== 1'b0 ||
            pc_if.coin_reject !== 1'b0 || pc_if.paid_total !== 8'd0 || pc_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got st=%0d gate=%b pulse=%b rej=%b paid=%0d busy=%b expected all zero",
                     nm, pc_if.state, pc_if.gate_open, pc_if.change_pulse, pc_if.coin_reject,
                     pc_if.paid_total, pc_if.busy);
        end
    endtask

    typedef struct {
        bit cv; int cost; bit kv; int code; bit cn;
        int e_state; int e_paid; bit e_rej; bit e_pulse; bit e_gate;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        pc_if.cost = 8'd0; pc_if.cost_valid = 1'b0; pc_if.coin_valid = 1'b0;
        pc_if.coin_value = 2'd0; pc_if.cancel = 1'b0;
        model_reset();
        #2;
        chk_reset("reset_state");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Vector table: cost 6, coins 5 and 2, ignored cost_valid, coin in OPEN, cancel in OPEN.
        tbl[0] = '{1, 6,  0, 0, 0, ST_COLLECT, 0, 0, 0, 0};
        tbl[1] = '{0, 0,  1, 2, 0, ST_COLLECT, 5, 0, 0, 0};
        tbl[2] = '{1, 99, 1, 1, 0, ST_CHANGE,  7, 0, 1, 0};
        tbl[3] = '{0, 0,  0, 0, 0, ST_OPEN,    7, 0, 0, 1};
        tbl[4] = '{0, 0,  1, 3, 0, ST_OPEN,    7, 1, 0, 1};
        tbl[5] = '{0, 0,  0, 0, 1, ST_OPEN,    7, 0, 0, 1};
        pulse_cnt = 0; gate_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].cv, tbl[i].cost, tbl[i].kv, tbl[i].code, tbl[i].cn);
            checks++;
            if (pc_if.state !== 3'(tbl[i].e_state) || pc_if.paid_total !== 8'(tbl[i].e_paid) ||
                pc_if.coin_reject !== tbl[i].e_rej || pc_if.change_pulse !== tbl[i].e_pulse ||
                pc_if.gate_open !== tbl[i].e_gate) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d paid=%0d rej=%b pulse=%b gate=%b expected st=%0d paid=%0d rej=%b pulse=%b gate=%b",
                         i, pc_if.state, pc_if.paid_total, pc_if.coin_reject, pc_if.change_pulse, pc_if.gate_open,
                         tbl[i].e_state, tbl[i].e_paid, tbl[i].e_rej, tbl[i].e_pulse, tbl[i].e_gate);
            end
        end
        drain("vec");
        chk("vec_pulses", pulse_cnt, 1);
        chk("vec_gate_cycles", gate_cnt, 16);
        chk("vec_paid_held", int'(pc_if.paid_total), 7);

        // Exact payment: OPEN on the edge after the coin, 16 gate cycles, no change.
        pulse_cnt = 0; gate_cnt = 0;
        cyc(1, 10, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        chk("exact_open_after_coin", int'(pc_if.state), ST_OPEN);
        drain("exact");
        chk("exact_pulses", pulse_cnt, 0);
        chk("exact_gate_cycles", gate_cnt, 16);
        chk("exact_busy_after", int'(pc_if.busy), 0);

        // Cancel after 10 units paid: 10 refund pulses, gate never opens.
        pulse_cnt = 0; gate_cnt = 0;
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 1, 2, 0);
        cyc(0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 1);
        chk("cancel_refund_state", int'(pc_if.state), ST_REFUND);
        drain("cancel");
        chk("cancel_pulses", pulse_cnt, 10);
        chk("cancel_gate_cycles", gate_cnt, 0);

        // Timeout: 255 idle cycles after a 2-unit coin, then 2 refund pulses.
        pulse_cnt = 0; gate_cnt = 0;
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        n = 0;
        while (pc_if.state == 3'd1 && n < 400) begin idle(); n++; end
        chk("timeout_idle_cycles", n, 255);
        chk("timeout_state", int'(pc_if.state), ST_REFUND);
        drain("timeout");
        chk("timeout_pulses", pulse_cnt, 2);

        // Cancel with a coin in the same cycle: refund includes that coin.
        pulse_cnt = 0;
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 1);
        chk("cancel_coin_paid", int'(pc_if.paid_total), 3);
        drain("cancel_coin");
        chk("cancel_coin_pulses", pulse_cnt, 3);

        // Completing coin plus cancel together: completion wins.
        cyc(1, 4, 0, 0, 0);
        cyc(0, 0, 1, 2, 1);
        chk("complete_beats_cancel", int'(pc_if.state), ST_CHANGE);
        drain("complete_cancel");

        // Overflow: paid 250, coin 10 rejected, then 5 completes the 255 fee exactly.
        cyc(1, 255, 0, 0, 0);
        for (int i = 0; i < 25; i++) cyc(0, 0, 1, 3, 0);
        chk("ovf_paid_250", int'(pc_if.paid_total), 250);
        cyc(0, 0, 1, 3, 0);
        chk("ovf_reject", int'(pc_if.coin_reject), 1);
        chk("ovf_paid_hold", int'(pc_if.paid_total), 250);
        cyc(0, 0, 1, 2, 0);
        chk("ovf_exact_open", int'(pc_if.state), ST_OPEN);
        drain("ovf");

        // Zero fee goes straight to OPEN.
        cyc(1, 0, 0, 0, 0);
        chk("zero_cost_open", int'(pc_if.state), ST_OPEN);
        drain("zero");

        // Reset mid-CHANGE after 3 of 8 pulses.
        pulse_cnt = 0;
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        idle();
        idle();
        chk("midchange_pulses_before", pulse_cnt, 3);
        #2;
        reset = 1'b0;
        #1;
        chk_reset("midchange_reset_immediate");
        model_reset();
        @(posedge clk); #1;
        chk_reset("midchange_reset_held");
        reset = 1'b1;
        pulse_cnt = 0;
        repeat (12) idle();
        chk("post_reset_pulses", pulse_cnt, 0);
        cyc(1, 5, 0, 0, 0);
        chk("post_reset_first_edge", int'(pc_if.state), ST_COLLECT);
        cyc(0, 0, 0, 0, 1);
        chk("cancel_empty_idle", int'(pc_if.state), ST_IDLE);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit cv = ($urandom_range(0, 9) == 0);
            int cost = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 40);
            bit kv = ($urandom_range(0, 99) < 35);
            int code = $urandom_range(0, 3);
            bit cn = ($urandom_range(0, 39) == 0);
            cyc(cv, cost, kv, code, cn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/payment_collector.md
PAYMENT_COLLECTOR -- requirements
Module: payment_collector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: idle cycles allowed in COLLECT before auto-refund.
REQ-002 SHALL have parameter GATE_HOLD, default 16: cycles gate_open stays high.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 SHALL have port cost  input  8  fee due, unsigned units; sampled only when cost_valid=1.
REQ-006 SHALL have port cost_valid  input  1  one-cycle pulse that starts a transaction.
REQ-007 SHALL have port coin_valid  input  1  one-cycle pulse per inserted coin.
REQ-008 SHALL have port coin_value  input  2  coin code: 00=1, 01=2, 10=5, 11=10 units.
REQ-009 SHALL have port cancel  input  1  user abort request.
REQ-010 SHALL have port gate_open  output  1  exit gate release.
REQ-011 SHALL have port change_pulse  output  1  one unit of change or refund dispensed per high cycle.
REQ-012 SHALL have port coin_reject  output  1  one-cycle pulse; coin not accepted.
REQ-013 SHALL have port paid_total  output  8  units accepted in the current transaction.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port state  output  3  encoding: IDLE=0, COLLECT=1, CHANGE=2, OPEN=3, REFUND=4.

Function
REQ-016 SHALL have states IDLE, COLLECT, CHANGE, OPEN and REFUND, all registered, with all outputs driven from registers.
REQ-017 IDLE: on cost_valid, SHALL latch due=cost, clear paid_total and the idle timer, then enter COLLECT; if cost=0, SHALL enter OPEN instead.
REQ-018 cost_valid outside IDLE SHALL be ignored; the latched due SHALL be unchanged.
REQ-019 COLLECT: a coin with paid_total + value <= 255 SHALL be accepted: paid_total updates next cycle and the idle timer clears.
REQ-020 COLLECT: a coin with paid_total + value > 255 SHALL be rejected: coin_reject=1 for 1 cycle, paid_total unchanged; the sum is computed 9 bits wide.
REQ-021 coin_valid in any state except COLLECT SHALL produce coin_reject=1 for 1 cycle and no other effect.
REQ-022 COLLECT: when accepted total >= due, SHALL enter CHANGE with change_left = total - due if the difference > 0, else OPEN, on the same edge that updates paid_total.
REQ-023 COLLECT: the idle timer SHALL increment each cycle with no accepted coin.
REQ-024 When the idle timer reaches TIMEOUT_CYCLES, SHALL behave exactly as cancel.
REQ-025 COLLECT cancel: SHALL enter REFUND with refund_left = paid_total if paid_total > 0, else IDLE.
REQ-026 cancel and coin_valid in the same cycle: the coin SHALL be accepted per REQ-019/020 first, then cancel applies, so the refund includes that coin.
REQ-027 A completing coin and cancel in the same cycle: payment completion SHALL win (CHANGE/OPEN).
REQ-028 CHANGE: change_pulse=1 every cycle, change_left decrements per pulse; exactly (total - due) pulses; after the last pulse SHALL enter OPEN.
REQ-029 REFUND: exactly refund_left change_pulse cycles, gate_open stays 0, then IDLE; cancel is ignored.
REQ-030 OPEN: gate_open=1 for exactly GATE_HOLD consecutive cycles, then IDLE with gate_open=0.
REQ-031 cancel outside COLLECT SHALL be ignored.
REQ-032 paid_total SHALL hold its value through CHANGE/OPEN/REFUND and clear only on the next cost_valid or reset.

Reset
REQ-033 On reset=0 SHALL immediately force: state=IDLE, gate_open=0, change_pulse=0, coin_reject=0, paid_total=0, busy=0, due=0, all counters 0.
REQ-034 Reset asserted mid-CHANGE/REFUND SHALL abort dispensing; no further change_pulse after deassertion.
REQ-035 After reset deasserts, the first rising edge SHALL process inputs normally.

Verification
REQ-036 cost=6, coins 5,2 -> exactly 1 change_pulse, then gate_open high for 16 cycles, paid_total=7.
REQ-037 cost=10, coin 10 -> no change_pulse; OPEN on the edge after the coin; busy=0 after 16 gate cycles.
REQ-038 cost=20, coins 5,5 then cancel -> 10 change_pulse cycles, gate_open never 1, returns to IDLE.
REQ-039 cost=20, coin 2, then 255 idle cycles -> REFUND with 2 pulses; cancel and coin in the same cycle (coin 1, paid 2) -> 3 refund pulses.
REQ-040 paid_total=250, coin 10 -> coin_reject pulse, paid_total stays 250; coin while in OPEN -> coin_reject.
REQ-041 cost=0 -> OPEN directly; reset pulse mid-CHANGE (3 of 8 pulses done) -> all outputs 0 immediately, state=IDLE.
